// File: rtl/bsg_counter_pkg.sv
// ============================================================================
//  Module   : bsg_counter_pkg
//  Brief    : Shared types and width helpers for the bsg counter family.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bsg_counter_pkg;

    // Bound policy applied when a step carries the count past 0 or max_val_p
    typedef enum logic {
        e_cnt_wrap     = 1'b0,
        e_cnt_saturate = 1'b1
    } bsg_counter_mode_e;

    // Bits needed to hold every value in 0..max_val
    function automatic int bsg_counter_ptr_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage : bsg_counter_pkg

`default_nettype wire

// File: rtl/bsg_counter_clear_up_down_chan.sv
// ============================================================================
//  Module   : bsg_counter_clear_up_down_chan
//  Brief    : One up/down counter channel with synchronous clear, multi-unit
//             steps, wrap/saturate bound handling and sticky over/underflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_counter_clear_up_down_chan
    import bsg_counter_pkg::*;
#(
    parameter int max_val_p     = 10000000,
    parameter int max_step_p    = 1,
    parameter int saturate_p    = 0,
    parameter int ptr_width_lp  = bsg_counter_ptr_width(max_val_p),
    parameter int step_width_lp = $clog2(max_step_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    input  logic [step_width_lp-1:0] up_i,
    input  logic [step_width_lp-1:0] down_i,
    output logic [ptr_width_lp-1:0]  count_o,
    output logic                     zero_o,
    output logic                     max_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    // Two extra bits: one for the positive excursion up to 2*max_val_p, one sign
    localparam int c_sum_w = ptr_width_lp + 2;

    localparam bsg_counter_mode_e c_mode =
        (saturate_p != 0) ? e_cnt_saturate : e_cnt_wrap;

    localparam logic [ptr_width_lp-1:0]         c_max      = ptr_width_lp'(max_val_p);
    localparam logic signed [c_sum_w-1:0]       c_max_s    = c_sum_w'(max_val_p);
    localparam logic [step_width_lp-1:0]        c_max_step = step_width_lp'(max_step_p);
    // Wrap correction is done on the low bits only; modulo-2^n arithmetic keeps
    // the result exact because the corrected value always fits in ptr_width_lp.
    localparam logic [ptr_width_lp-1:0]         c_mod_lo   = ptr_width_lp'(max_val_p + 1);

    // A single wrap correction is only sufficient when a step cannot exceed the range
    if (max_step_p > max_val_p) begin : g_step_check
        $error("bsg_counter_clear_up_down_chan: max_step_p must be <= max_val_p");
    end

    logic [ptr_width_lp-1:0]   count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;

    logic [ptr_width_lp-1:0]   w_base;
    logic signed [c_sum_w-1:0] w_sum;
    logic [ptr_width_lp-1:0]   w_sum_lo;
    logic                      w_over;
    logic                      w_under;

    // Clear substitutes zero as the base so a step in the same cycle is kept
    assign w_base   = clear_i ? '0 : count_q;
    assign w_sum    = $signed({2'b00, w_base})
                    + $signed({{(c_sum_w - step_width_lp){1'b0}}, up_i})
                    - $signed({{(c_sum_w - step_width_lp){1'b0}}, down_i});
    assign w_sum_lo = w_sum[ptr_width_lp-1:0];
    assign w_over   = (w_sum > c_max_s);
    assign w_under  = w_sum[c_sum_w-1];

    // Next count and sticky flags from the netted step and the bound policy
    always_comb begin
        count_d     = w_sum_lo;
        overflow_d  = (overflow_q  & ~clear_i) | w_over;
        underflow_d = (underflow_q & ~clear_i) | w_under;
        if (w_over) begin
            if (c_mode == e_cnt_saturate) count_d = c_max;
            else                          count_d = w_sum_lo - c_mod_lo;
        end else if (w_under) begin
            if (c_mode == e_cnt_saturate) count_d = '0;
            else                          count_d = w_sum_lo + c_mod_lo;
        end
    end

    // Count and flag registers, asynchronously forced to zero by reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign zero_o      = (count_q == '0);
    assign max_o       = (count_q == c_max);
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Steps above max_step_p would break the single-correction wrap arithmetic
    a_step_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (up_i <= c_max_step) && (down_i <= c_max_step))
        else $error("bsg_counter_clear_up_down_chan: step exceeds max_step_p");

endmodule : bsg_counter_clear_up_down_chan

`default_nettype wire

// File: rtl/bsg_counter_bank_clear_up_down.sv
// ============================================================================
//  Module   : bsg_counter_bank_clear_up_down
//  Brief    : Bank of els_p independent up/down counters with clear,
//             multi-unit steps and wrap/saturate bound handling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bsg_counter_bank_clear_up_down
    import bsg_counter_pkg::*;
#(
    parameter  int els_p         = 4,
    parameter  int max_val_p     = 10000000,
    parameter  int max_step_p    = 1,
    parameter  int saturate_p    = 0,
    localparam int ptr_width_lp  = bsg_counter_ptr_width(max_val_p),
    localparam int step_width_lp = $clog2(max_step_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [els_p-1:0]                 clear_i,
    input  logic [els_p*step_width_lp-1:0]   up_i,
    input  logic [els_p*step_width_lp-1:0]   down_i,
    output logic [els_p*ptr_width_lp-1:0]    count_o,
    output logic [els_p-1:0]                 zero_o,
    output logic [els_p-1:0]                 max_o,
    output logic [els_p-1:0]                 overflow_o,
    output logic [els_p-1:0]                 underflow_o
);

    // One self-contained channel per element; only port slicing here
    for (genvar i = 0; i < els_p; i++) begin : g_chan
        bsg_counter_clear_up_down_chan #(
            .max_val_p     (max_val_p),
            .max_step_p    (max_step_p),
            .saturate_p    (saturate_p),
            .ptr_width_lp  (ptr_width_lp),
            .step_width_lp (step_width_lp)
        ) u_chan (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .clear_i     (clear_i[i]),
            .up_i        (up_i[i*step_width_lp +: step_width_lp]),
            .down_i      (down_i[i*step_width_lp +: step_width_lp]),
            .count_o     (count_o[i*ptr_width_lp +: ptr_width_lp]),
            .zero_o      (zero_o[i]),
            .max_o       (max_o[i]),
            .overflow_o  (overflow_o[i]),
            .underflow_o (underflow_o[i])
        );
    end

endmodule : bsg_counter_bank_clear_up_down

`default_nettype wire

// File: tb/tb_bsg_counter_bank_clear_up_down.sv
// ============================================================================
//  Module   : tb_bsg_counter_bank_clear_up_down
//  Brief    : Self-checking bench: a wrap-mode bank and a saturate-mode bank.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bsg_counter_bank_clear_up_down;

    localparam int ELS    = 4;
    // Wrap bank bound chosen so the top count is 9999999
    localparam int W_MAX  = 9999999;
    localparam int W_PW   = 24;
    localparam int S_MAX  = 10;
    localparam int S_STEP = 3;
    localparam int S_PW   = 4;
    localparam int S_SW   = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic [ELS-1:0]      w_clear, w_up, w_down;
    logic [ELS*W_PW-1:0] w_count;
    logic [ELS-1:0]      w_zero, w_maxf, w_ovf, w_unf;

    logic [ELS-1:0]      s_clear;
    logic [ELS*S_SW-1:0] s_up, s_down;
    logic [ELS*S_PW-1:0] s_count;
    logic [ELS-1:0]      s_zero, s_maxf, s_ovf, s_unf;

    always #5 clk = ~clk;

    bsg_counter_bank_clear_up_down #(
        .els_p(ELS), .max_val_p(W_MAX), .max_step_p(1), .saturate_p(0)
    ) dut_wrap (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(w_clear), .up_i(w_up), .down_i(w_down),
        .count_o(w_count), .zero_o(w_zero), .max_o(w_maxf),
        .overflow_o(w_ovf), .underflow_o(w_unf)
    );

    bsg_counter_bank_clear_up_down #(
        .els_p(ELS), .max_val_p(S_MAX), .max_step_p(S_STEP), .saturate_p(1)
    ) dut_sat (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(s_clear), .up_i(s_up), .down_i(s_down),
        .count_o(s_count), .zero_o(s_zero), .max_o(s_maxf),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: index 0 = wrap bank, 1 = saturate bank
    int m_cnt [2][ELS];
    int m_ovf [2][ELS];
    int m_unf [2][ELS];

    typedef struct {
        int clr;
        int up;
        int dn;
        int cnt;
        int ovf;
        int unf;
    } vec_t;
    vec_t vecs [20];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_w(input string tag, input int ch, input int cnt, input int ovf, input int unf);
        chk($sformatf("%s w%0d count", tag, ch), longint'(w_count[ch*W_PW +: W_PW]), cnt);
        chk($sformatf("%s w%0d zero", tag, ch), longint'(w_zero[ch]), (cnt == 0) ? 1 : 0);
        chk($sformatf("%s w%0d max", tag, ch), longint'(w_maxf[ch]), (cnt == W_MAX) ? 1 : 0);
        chk($sformatf("%s w%0d ovf", tag, ch), longint'(w_ovf[ch]), ovf);
        chk($sformatf("%s w%0d unf", tag, ch), longint'(w_unf[ch]), unf);
    endtask

    task automatic chk_s(input string tag, input int ch, input int cnt, input int ovf, input int unf);
        chk($sformatf("%s s%0d count", tag, ch), longint'(s_count[ch*S_PW +: S_PW]), cnt);
        chk($sformatf("%s s%0d zero", tag, ch), longint'(s_zero[ch]), (cnt == 0) ? 1 : 0);
        chk($sformatf("%s s%0d max", tag, ch), longint'(s_maxf[ch]), (cnt == S_MAX) ? 1 : 0);
        chk($sformatf("%s s%0d ovf", tag, ch), longint'(s_ovf[ch]), ovf);
        chk($sformatf("%s s%0d unf", tag, ch), longint'(s_unf[ch]), unf);
    endtask

    // Reference: integer arithmetic on the true value, then the bank's policy
    task automatic model_step(input int d, input int ch, input int clr, input int up, input int dn);
        int maxv;
        int s;
        maxv = (d == 0) ? W_MAX : S_MAX;
        s    = (clr != 0 ? 0 : m_cnt[d][ch]) + up - dn;
        if (clr != 0) begin
            m_ovf[d][ch] = 0;
            m_unf[d][ch] = 0;
        end
        if (s > maxv) m_ovf[d][ch] = 1;
        if (s < 0)    m_unf[d][ch] = 1;
        if (d == 1) m_cnt[d][ch] = (s > maxv) ? maxv : ((s < 0) ? 0 : s);
        else        m_cnt[d][ch] = ((s % (maxv + 1)) + (maxv + 1)) % (maxv + 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_reset(input string tag);
        for (int ch = 0; ch < ELS; ch++) begin
            chk_w(tag, ch, 0, 0, 0);
            chk_s(tag, ch, 0, 0, 0);
        end
    endtask

    initial begin
        // Saturate bank, channel 0: {clear, up, down, count, overflow, underflow}
        vecs = '{
            '{0, 3, 0,  3, 0, 0}, '{0, 3, 0,  6, 0, 0}, '{0, 3, 0,  9, 0, 0},
            '{0, 3, 0, 10, 1, 0}, '{0, 3, 0, 10, 1, 0}, '{1, 3, 0,  3, 0, 0},
            '{0, 3, 0,  6, 0, 0}, '{0, 3, 0,  9, 0, 0}, '{0, 1, 0, 10, 0, 0},
            '{0, 2, 2, 10, 0, 0}, '{0, 0, 3,  7, 0, 0}, '{0, 0, 3,  4, 0, 0},
            '{0, 0, 3,  1, 0, 0}, '{0, 0, 3,  0, 0, 1}, '{1, 0, 0,  0, 0, 0},
            '{0, 1, 1,  0, 0, 0}, '{0, 0, 1,  0, 0, 1}, '{1, 0, 2,  0, 0, 1},
            '{1, 0, 0,  0, 0, 0}, '{0, 2, 1,  1, 0, 0}
        };

        rst_n   = 1'b0;
        w_clear = '0; w_up = '0; w_down = '0;
        s_clear = '0; s_up = '0; s_down = '0;
        repeat (2) tick();
        chk_all_reset("reset");
        rst_n = 1'b1;
        tick();

        // Wrap bank, channel 0: crossings in both directions, sticky flags
        w_down[0] = 1'b1; tick(); chk_w("wrap_dn_from0", 0, W_MAX, 0, 1);
        w_down[0] = 1'b0; w_up[0] = 1'b1; tick(); chk_w("wrap_up_at_max", 0, 0, 1, 1);
        w_up[0] = 1'b0; w_down[0] = 1'b1; tick(); chk_w("wrap_dn_again", 0, W_MAX, 1, 1);
        w_down[0] = 1'b0; w_up[0] = 1'b1;
        repeat (10) tick();
        chk_w("wrap_to9", 0, 9, 1, 1);
        w_clear[0] = 1'b1; tick(); chk_w("clear_and_up", 0, 1, 0, 0);
        w_clear[0] = 1'b0;
        repeat (8) tick();
        chk_w("back_to9", 0, 9, 0, 0);
        w_up[0] = 1'b0; w_clear[0] = 1'b1; tick(); chk_w("clear_no_step", 0, 0, 0, 0);
        w_down[0] = 1'b1; tick(); chk_w("clear_with_cross", 0, W_MAX, 0, 1);
        w_down[0] = 1'b0; tick(); chk_w("clear_idle", 0, 0, 0, 0);
        w_clear[0] = 1'b0;
        for (int ch = 1; ch < ELS; ch++) chk_w("wrap_others_idle", ch, 0, 0, 0);

        // Saturate bank table on channel 0
        for (int i = 0; i < 20; i++) begin
            s_clear[0]   = vecs[i].clr[0];
            s_up[1:0]    = 2'(vecs[i].up);
            s_down[1:0]  = 2'(vecs[i].dn);
            tick();
            chk_s($sformatf("sat_vec%0d", i), 0, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end
        s_clear = '0; s_up = '0; s_down = '0;
        for (int ch = 1; ch < ELS; ch++) chk_s("sat_others_idle", ch, 0, 0, 0);

        // Random traffic on wrap channel 2 only; all channels checked each cycle
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < ELS; ch++) begin
                m_cnt[d][ch] = 0; m_ovf[d][ch] = 0; m_unf[d][ch] = 0;
            end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int clr, up, dn;
            clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
            up  = int'($urandom_range(0, 1));
            dn  = int'($urandom_range(0, 1));
            w_clear[2] = (clr != 0);
            w_up[2]    = (up  != 0);
            w_down[2]  = (dn  != 0);
            model_step(0, 2, clr, up, dn);
            tick();
            for (int ch = 0; ch < ELS; ch++)
                chk_w($sformatf("rand_wrap_c%0d", cyc), ch, m_cnt[0][ch], m_ovf[0][ch], m_unf[0][ch]);
        end
        w_clear = '0; w_up = '0; w_down = '0;

        // Random traffic on every saturate channel after a common clear
        s_clear = '1; tick(); s_clear = '0;
        for (int ch = 0; ch < ELS; ch++) chk_s("sat_clear_all", ch, 0, 0, 0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int ch = 0; ch < ELS; ch++) begin
                int clr, up, dn;
                clr = ($urandom_range(0, 9) == 0) ? 1 : 0;
                up  = int'($urandom_range(0, S_STEP));
                dn  = int'($urandom_range(0, S_STEP));
                s_clear[ch]             = (clr != 0);
                s_up[ch*S_SW +: S_SW]   = 2'(up);
                s_down[ch*S_SW +: S_SW] = 2'(dn);
                model_step(1, ch, clr, up, dn);
            end
            tick();
            for (int ch = 0; ch < ELS; ch++)
                chk_s($sformatf("rand_sat_c%0d", cyc), ch, m_cnt[1][ch], m_ovf[1][ch], m_unf[1][ch]);
        end
        s_clear = '0; s_up = '0; s_down = '0;

        // Asynchronous reset in the middle of counting at 57
        w_clear[0] = 1'b1; w_up[0] = 1'b1; tick();
        w_clear[0] = 1'b0;
        repeat (56) tick();
        chk_w("pre_reset", 0, 57, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_reset("async_reset");
        tick();
        chk_all_reset("reset_held");
        w_up = '0;
        rst_n = 1'b1;
        tick();
        chk_all_reset("after_release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bsg_counter_bank_clear_up_down

`default_nettype wire
